imem_load_ctrl: RTL and testbench
=================================

// Module: imem_load_ctrl
// PURPOSE
//  Consumes the debug program-load stream (debug_sig/debug_addr/debug_instr/start) and writes each beat into
//  instruction memory through a write port that may stall. Buffers beats in a small FIFO and checks the address
//  sequence. Keeps a running checksum and word count. Releases the core (core_run) only after all beats are drained
//  and start has been seen. Sits between the debug source and the IMEM write port / core fetch enable.
// PARAMETERS
//  AW     10  IMEM word-address width; the IMEM holds 2**AW words
//  DEPTH  4   load FIFO depth in entries; power of two, >=2
// PORTS
//  clk           in   1   clock
//  rst           in   1   reset, asynchronous, active-high
//  debug_sig     in   1   beat valid: debug_addr/debug_instr carry a word this cycle
//  debug_addr    in   32  word address of the beat (word index, not byte)
//  debug_instr   in   32  instruction word of the beat
//  start         in   1   load finished; source asserts it after the last beat
//  imem_wready   in   1   IMEM accepts a write this cycle
//  imem_we       out  1   IMEM write strobe
//  imem_waddr    out  AW  IMEM write word address
//  imem_wdata    out  32  IMEM write data
//  core_run      out  1   core may fetch; sticky until rst
//  load_done     out  1   all accepted beats written without error; sticky
//  load_count    out  16  number of IMEM writes performed; saturates at 16'hFFFF
//  checksum      out  32  sum mod 2^32 of every imem_wdata written
//  addr_err      out  1   sticky: out-of-range or non-sequential address seen
//  ovf_err       out  1   sticky: beat dropped because the FIFO was full
// BEHAVIOUR
//  - Reset (async, mid-operation included): state=IDLE, FIFO emptied, every output 0, expected-address register 0.
//  - States:
//    - IDLE: debug_sig=1 & start=0 -> push beat, go to LOAD. start=1 with no beat ever accepted -> RUN.
//    - LOAD: each cycle with debug_sig=1 & start=0 pushes {addr[AW-1:0],instr}. debug_sig=0 cycles are gaps and are
//      ignored. start=1 -> DRAIN; a beat in the same cycle start rises is discarded (not an error).
//    - DRAIN: no pushes; pop until FIFO empty, then go to RUN if neither error flag is set, otherwise to ERROR.
//    - RUN: core_run=1, load_done=1; debug inputs ignored; terminal until rst.
//    - ERROR: core_run=0, load_done=0, flags held; terminal until rst.
//  - Address check, evaluated at push:
//    - debug_addr[31:AW] != 0 -> beat dropped, addr_err=1.
//    - The first beat sets expected = addr+1. Every later beat must equal expected, otherwise addr_err=1.
//    - A non-sequential but in-range beat is still written, and expected = addr+1.
//  - FIFO push when full: the beat is dropped and ovf_err=1. The exception is a pop in the same cycle; then the push
//    is accepted.
//  - Write port:
//    - imem_we = !fifo_empty & imem_wready in LOAD/DRAIN. It is combinational from the registered FIFO head, so
//      imem_waddr/imem_wdata are the FIFO head.
//    - A pop occurs exactly when imem_we=1.
//    - Minimum latency from push to write is 1 cycle.
//    - imem_waddr/imem_wdata are 0 whenever imem_we=0.
//  - On each write: load_count+1 (saturating) and checksum += imem_wdata (wraps mod 2^32). Both update on the clock
//    edge after imem_we.
//  - core_run rises on the first cycle in state RUN. It is never asserted while the FIFO is non-empty.
// STRUCTURE
//  - Package imem_load_pkg: typedef enum logic [2:0] {IDLE,LOAD,DRAIN,RUN,ERROR} load_state_e;
//    typedef struct packed {logic [AW-1:0] addr; logic [31:0] data;} load_beat_t (parameterised via localparam
//    in the module); LOAD_CNT_W=16.
//  - One sub-module: load_fifo (sync FIFO, DEPTH x (AW+32), push/pop/full/empty, registered head, simultaneous
//    push+pop when full allowed). The FSM, address check and counters stay in imem_load_ctrl.
// TESTING
//  1. Beats addr 0..14 back-to-back, imem_wready=1, start 2 cycles after the last beat -> 15 writes at waddr
//     0..14, load_count=15, checksum=sum of the words, core_run=1, both err=0.
//  2. imem_wready toggling 1,0,0,1..., DEPTH=4, 6 back-to-back beats -> ovf_err=1, dropped beats absent from
//     IMEM, ERROR after drain, core_run stays 0.
//  3. Beats addr 0,1,3 -> addr 3 written, addr_err=1 at the third push, final state ERROR, load_count=3.
//  4. debug_addr=32'h0000_0400 (AW=10) -> no write, addr_err=1; debug_sig=1 with start=1 on the same cycle ->
//     beat discarded, no err.
//  5. rst pulsed mid-LOAD with 2 entries queued -> imem_we=0 immediately, all outputs 0; a fresh load of addr
//     0..3 then completes with load_count=4.
//  6. start=1 with no beats, in IDLE -> core_run=1 next cycle, load_count=0, checksum=0.

Source files
------------

// File: rtl/imem_load_pkg.sv
// Shared types and constants for the IMEM program-load controller.
//   load_state_e : controller state (IDLE, LOAD, DRAIN, RUN, ERROR)
//   LOAD_CNT_W   : width of the IMEM write counter
//   sat_inc      : saturating increment for the write counter
package imem_load_pkg;

  localparam int unsigned LOAD_CNT_W = 16;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    DRAIN,
    RUN,
    ERROR
  } load_state_e;

  function automatic logic [LOAD_CNT_W-1:0] sat_inc(input logic [LOAD_CNT_W-1:0] v);
    return (v == '1) ? v : v + LOAD_CNT_W'(1);
  endfunction

endpackage

// File: rtl/imem_load_ctrl_if.sv
// Bus bundle between the debug load source / IMEM write port and the
// load controller.
//   debug_sig/debug_addr/debug_instr/start : program-load stream from debug
//   imem_wready                            : IMEM can take a write this cycle
//   imem_we/imem_waddr/imem_wdata          : IMEM write port
// Modports: slave = controller view, master = environment view.
interface imem_load_ctrl_if #(
  parameter int unsigned AW = 10
) ();

  logic          debug_sig;
  logic [31:0]   debug_addr;
  logic [31:0]   debug_instr;
  logic          start;
  logic          imem_wready;
  logic          imem_we;
  logic [AW-1:0] imem_waddr;
  logic [31:0]   imem_wdata;

  modport slave (
    input  debug_sig, debug_addr, debug_instr, start, imem_wready,
    output imem_we, imem_waddr, imem_wdata
  );

  modport master (
    output debug_sig, debug_addr, debug_instr, start, imem_wready,
    input  imem_we, imem_waddr, imem_wdata
  );

endinterface

// File: rtl/imem_load_ctrl_fifo.sv
// load_fifo: synchronous FIFO holding load beats waiting for the IMEM.
//   clk, rst  : clock, asynchronous active-high reset (empties the FIFO)
//   push, din : write request and data (ignored when full unless popping)
//   pop       : remove the head entry (ignored when empty)
//   dout      : current head entry, read from registered storage
//   full/empty: occupancy flags
module load_fifo #(
  parameter int unsigned W     = 42,
  parameter int unsigned DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic [W-1:0] din,
  input  logic         pop,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty
);

  localparam int unsigned PW = $clog2(DEPTH);

  logic [W-1:0] mem [DEPTH];
  logic [PW:0]  wr_ptr;
  logic [PW:0]  rd_ptr;
  logic         wr_en;
  logic         rd_en;

  // Pointers carry one extra wrap bit to tell full from empty.
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[PW] != rd_ptr[PW]) && (wr_ptr[PW-1:0] == rd_ptr[PW-1:0]);

  // A pop in the same cycle frees the slot, so a push into a full FIFO is
  // still accepted then.
  assign rd_en = pop && !empty;
  assign wr_en = push && (!full || rd_en);

  assign dout = mem[rd_ptr[PW-1:0]];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + (PW+1)'(1);
      if (rd_en) rd_ptr <= rd_ptr + (PW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr[PW-1:0]] <= din;
  end

endmodule

// File: rtl/imem_load_ctrl.sv
// imem_load_ctrl: takes the debug program-load stream, buffers each beat,
// checks the address sequence and writes the beats into IMEM through a
// stallable write port. Releases the core once everything is written and
// start has been seen.
//   clk, rst    : clock, asynchronous active-high reset
//   bus         : debug stream in, IMEM write port out (slave modport)
//   core_run    : core may fetch (sticky until rst)
//   load_done   : load finished without error (sticky)
//   load_count  : IMEM writes performed, saturating
//   checksum    : sum mod 2^32 of all written words
//   addr_err    : sticky out-of-range / non-sequential address flag
//   ovf_err     : sticky beat-dropped-on-full flag
module imem_load_ctrl
  import imem_load_pkg::*;
#(
  parameter int unsigned AW    = 10,
  parameter int unsigned DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  imem_load_ctrl_if.slave       bus,
  output logic                  core_run,
  output logic                  load_done,
  output logic [LOAD_CNT_W-1:0] load_count,
  output logic [31:0]           checksum,
  output logic                  addr_err,
  output logic                  ovf_err
);

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [31:0]   data;
  } load_beat_t;

  load_state_e   state;
  load_state_e   state_nxt;
  logic [AW-1:0] expected;
  logic          have_beat;
  logic          beat_ok;
  logic          in_range;
  logic          push;
  logic          pop;
  logic          full;
  logic          empty;
  load_beat_t    push_beat;
  load_beat_t    head;

  // A beat is only taken while loading; a beat coincident with start is
  // discarded silently.
  assign beat_ok   = ((state == IDLE) || (state == LOAD)) && bus.debug_sig && !bus.start;
  assign in_range  = (bus.debug_addr[31:AW] == '0);
  assign push      = beat_ok && in_range;
  assign push_beat = '{addr: bus.debug_addr[AW-1:0], data: bus.debug_instr};
  assign pop       = bus.imem_we;

  load_fifo #(
    .W     ($bits(load_beat_t)),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .din   (push_beat),
    .pop   (pop),
    .dout  (head),
    .full  (full),
    .empty (empty)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (bus.start)          state_nxt = RUN;
        else if (bus.debug_sig) state_nxt = LOAD;
      end
      LOAD: begin
        if (bus.start) state_nxt = DRAIN;
      end
      DRAIN: begin
        if (empty) state_nxt = (addr_err || ovf_err) ? ERROR : RUN;
      end
      RUN:     state_nxt = RUN;
      ERROR:   state_nxt = ERROR;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    bus.imem_we    = 1'b0;
    bus.imem_waddr = '0;
    bus.imem_wdata = '0;
    if (((state == LOAD) || (state == DRAIN)) && !empty && bus.imem_wready) begin
      bus.imem_we    = 1'b1;
      bus.imem_waddr = head.addr;
      bus.imem_wdata = head.data;
    end
    core_run  = (state == RUN);
    load_done = (state == RUN);
  end

  // Address checking and write accounting. The expected address follows
  // every in-range beat, even one dropped on overflow, so one lost beat
  // does not also show up as a sequence break.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_err   <= 1'b0;
      ovf_err    <= 1'b0;
      expected   <= '0;
      have_beat  <= 1'b0;
      load_count <= '0;
      checksum   <= '0;
    end else begin
      if (beat_ok) begin
        if (!in_range) begin
          addr_err <= 1'b1;
        end else begin
          if (have_beat && (bus.debug_addr[AW-1:0] != expected)) addr_err <= 1'b1;
          expected  <= bus.debug_addr[AW-1:0] + AW'(1);
          have_beat <= 1'b1;
          if (full && !pop) ovf_err <= 1'b1;
        end
      end
      if (bus.imem_we) begin
        load_count <= sat_inc(load_count);
        checksum   <= checksum + bus.imem_wdata;
      end
    end
  end

endmodule

// File: tb/tb_imem_load_ctrl.sv
module tb_imem_load_ctrl;

  localparam int unsigned AW    = 10;
  localparam int unsigned DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        core_run;
  logic        load_done;
  logic [15:0] load_count;
  logic [31:0] checksum;
  logic        addr_err;
  logic        ovf_err;

  always #5 clk = ~clk;

  imem_load_ctrl_if #(.AW(AW)) bus ();

  imem_load_ctrl #(.AW(AW), .DEPTH(DEPTH)) dut (
    .clk        (clk),
    .rst        (rst),
    .bus        (bus),
    .core_run   (core_run),
    .load_done  (load_done),
    .load_count (load_count),
    .checksum   (checksum),
    .addr_err   (addr_err),
    .ovf_err    (ovf_err)
  );

  int checks = 0;
  int errors = 0;

  // ---------------- reference model ----------------
  typedef struct {
    logic [AW-1:0] a;
    logic [31:0]   d;
  } beat_t;

  typedef enum {M_IDLE, M_LOAD, M_DRAIN, M_RUN, M_ERR} mph_e;

  beat_t       mq[$];   // beats the model holds in its buffer
  beat_t       sb[$];   // scoreboard: writes expected on the IMEM port
  bit          exp_we_now;
  mph_e        ph;
  bit          m_aerr, m_oerr, m_have;
  int unsigned m_exp;
  int unsigned m_cnt;
  logic [31:0] m_sum;

  task automatic model_reset();
    mq.delete();
    sb.delete();
    exp_we_now = 1'b0;
    ph     = M_IDLE;
    m_aerr = 1'b0;
    m_oerr = 1'b0;
    m_have = 1'b0;
    m_exp  = 0;
    m_cnt  = 0;
    m_sum  = '0;
  endtask

  // Predicts what the next clock edge does, given the inputs now applied.
  task automatic model_step(input bit sig, input logic [31:0] addr, input logic [31:0] data,
                            input bit st, input bit wr_rdy);
    int unsigned occ;
    bit          wr;
    bit          full;
    beat_t       b;
    occ  = mq.size();
    full = (occ == DEPTH);
    wr   = ((ph == M_LOAD) || (ph == M_DRAIN)) && (occ > 0) && wr_rdy;
    exp_we_now = wr;
    if (wr) begin
      b = mq.pop_front();
      sb.push_back(b);
      if (m_cnt < 65535) m_cnt++;
      m_sum += b.d;
    end
    if (((ph == M_IDLE) || (ph == M_LOAD)) && sig && !st) begin
      if ((addr >> AW) != 0) begin
        m_aerr = 1'b1;
      end else begin
        if (m_have && (addr != m_exp)) m_aerr = 1'b1;
        m_exp  = (addr + 1) % (1 << AW);
        m_have = 1'b1;
        if (full && !wr) m_oerr = 1'b1;
        else begin
          b.a = addr[AW-1:0];
          b.d = data;
          mq.push_back(b);
        end
      end
    end
    case (ph)
      M_IDLE:  if (st) ph = M_RUN; else if (sig) ph = M_LOAD;
      M_LOAD:  if (st) ph = M_DRAIN;
      M_DRAIN: if (occ == 0) ph = (m_aerr || m_oerr) ? M_ERR : M_RUN;
      default: ;
    endcase
  endtask

  // ---------------- checking helpers ----------------
  task automatic check_eq(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_status(input string tag);
    check_eq({tag, " core_run"},   core_run,   (ph == M_RUN));
    check_eq({tag, " load_done"},  load_done,  (ph == M_RUN));
    check_eq({tag, " load_count"}, load_count, m_cnt);
    check_eq({tag, " checksum"},   checksum,   m_sum);
    check_eq({tag, " addr_err"},   addr_err,   m_aerr);
    check_eq({tag, " ovf_err"},    ovf_err,    m_oerr);
  endtask

  // Monitor: compares the IMEM write port against the scoreboard.
  beat_t mon_b;
  always @(negedge clk) begin
    checks++;
    if (bus.imem_we !== exp_we_now) begin
      errors++;
      $display("FAIL imem_we: got %b expected %b at %0t", bus.imem_we, exp_we_now, $time);
    end
    if (exp_we_now && (sb.size() > 0)) begin
      mon_b = sb.pop_front();
      checks++;
      if ((bus.imem_waddr !== mon_b.a) || (bus.imem_wdata !== mon_b.d)) begin
        errors++;
        $display("FAIL write: got addr 0x%0h data 0x%0h expected addr 0x%0h data 0x%0h at %0t",
                 bus.imem_waddr, bus.imem_wdata, mon_b.a, mon_b.d, $time);
      end
    end else if (!exp_we_now) begin
      checks++;
      if ((bus.imem_waddr !== '0) || (bus.imem_wdata !== '0)) begin
        errors++;
        $display("FAIL idle_bus: got addr 0x%0h data 0x%0h expected 0 at %0t",
                 bus.imem_waddr, bus.imem_wdata, $time);
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic cyc(input bit sig, input logic [31:0] addr, input logic [31:0] data,
                     input bit st, input bit wr_rdy);
    @(posedge clk);
    #1;
    check_eq("core_run cycle", core_run, (ph == M_RUN));
    bus.debug_sig   = sig;
    bus.debug_addr  = addr;
    bus.debug_instr = data;
    bus.start       = st;
    bus.imem_wready = wr_rdy;
    model_step(sig, addr, data, st, wr_rdy);
  endtask

  task automatic idle(input int n, input int mode);
    for (int i = 0; i < n; i++)
      cyc(1'b0, '0, '0, 1'b0, (mode == 2) ? 1'($urandom_range(0, 1)) : 1'(mode));
  endtask

  // Asserts reset between edges so its asynchronous effect is visible at once.
  task automatic do_reset();
    @(posedge clk);
    #1;
    rst = 1'b1;
    bus.debug_sig   = 1'b0;
    bus.debug_addr  = '0;
    bus.debug_instr = '0;
    bus.start       = 1'b0;
    bus.imem_wready = 1'b1;
    model_reset();
    #1;
    check_eq("rst imem_we",    bus.imem_we, 0);
    check_eq("rst core_run",   core_run,    0);
    check_eq("rst load_done",  load_done,   0);
    check_eq("rst load_count", load_count,  0);
    check_eq("rst checksum",   checksum,    0);
    check_eq("rst addr_err",   addr_err,    0);
    check_eq("rst ovf_err",    ovf_err,     0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_step(1'b0, '0, '0, 1'b0, 1'b1);
  endtask

  logic [31:0] sum;
  logic [31:0] w;
  int unsigned a;
  int unsigned n;
  int unsigned r;

  initial begin
    bus.debug_sig   = 1'b0;
    bus.debug_addr  = '0;
    bus.debug_instr = '0;
    bus.start       = 1'b0;
    bus.imem_wready = 1'b0;
    model_reset();

    // 1: sequential 0..14, port always ready
    do_reset();
    sum = '0;
    for (int i = 0; i < 15; i++) begin
      w = $urandom;
      sum += w;
      cyc(1'b1, i, w, 1'b0, 1'b1);
    end
    idle(2, 1);
    cyc(1'b0, '0, '0, 1'b1, 1'b1);
    idle(8, 1);
    check_status("t1");
    check_eq("t1 count", load_count, 15);
    check_eq("t1 sum",   checksum,   sum);
    check_eq("t1 run",   core_run,   1);
    check_eq("t1 errs",  {addr_err, ovf_err}, 0);

    // 2: port ready 1,0,0 repeating, 6 back-to-back beats -> overflow
    do_reset();
    for (int k = 0; k < 6; k++) cyc(1'b1, k, $urandom, 1'b0, (k % 3) == 0);
    cyc(1'b0, '0, '0, 1'b1, 1'b1);
    for (int k = 7; k < 30; k++) cyc(1'b0, '0, '0, 1'b0, (k % 3) == 0);
    check_status("t2");
    check_eq("t2 ovf",   ovf_err,    1);
    check_eq("t2 run",   core_run,   0);
    check_eq("t2 count", load_count, 5);

    // 3: addresses 0,1,3
    do_reset();
    cyc(1'b1, 0, $urandom, 1'b0, 1'b1);
    cyc(1'b1, 1, $urandom, 1'b0, 1'b1);
    cyc(1'b1, 3, $urandom, 1'b0, 1'b1);
    cyc(1'b0, '0, '0, 1'b0, 1'b1);
    check_eq("t3 addr_err at push", addr_err, 1);
    cyc(1'b0, '0, '0, 1'b1, 1'b1);
    idle(6, 1);
    check_status("t3");
    check_eq("t3 count", load_count, 3);
    check_eq("t3 run",   core_run,   0);

    // 4a: out-of-range address, then beat coincident with start
    do_reset();
    cyc(1'b1, 32'h0000_0400, $urandom, 1'b0, 1'b1);
    cyc(1'b0, '0, '0, 1'b0, 1'b1);
    check_eq("t4 range err", addr_err, 1);
    cyc(1'b1, 0, $urandom, 1'b1, 1'b1);
    idle(6, 1);
    check_status("t4a");
    check_eq("t4a count", load_count, 0);

    // 4b: beat with start is discarded without error
    do_reset();
    cyc(1'b1, 0, $urandom, 1'b0, 1'b1);
    cyc(1'b1, 1, $urandom, 1'b0, 1'b1);
    cyc(1'b1, 2, $urandom, 1'b1, 1'b1);
    idle(6, 1);
    check_status("t4b");
    check_eq("t4b count", load_count, 2);
    check_eq("t4b err",   addr_err,   0);
    check_eq("t4b run",   core_run,   1);

    // 5: reset with two beats queued, then a fresh load
    do_reset();
    cyc(1'b1, 0, $urandom, 1'b0, 1'b0);
    cyc(1'b1, 1, $urandom, 1'b0, 1'b0);
    do_reset();
    for (int i = 0; i < 4; i++) cyc(1'b1, i, $urandom, 1'b0, 1'b1);
    cyc(1'b0, '0, '0, 1'b1, 1'b1);
    idle(6, 1);
    check_status("t5");
    check_eq("t5 count", load_count, 4);
    check_eq("t5 run",   core_run,   1);

    // 6: start with no beats
    do_reset();
    cyc(1'b0, '0, '0, 1'b1, 1'b1);
    cyc(1'b0, '0, '0, 1'b0, 1'b1);
    check_eq("t6 run",   core_run,   1);
    check_eq("t6 count", load_count, 0);
    check_eq("t6 sum",   checksum,   0);

    // Randomized loads: gaps, stalls, jumps, out-of-range, address wrap
    for (int it = 0; it < 8; it++) begin
      do_reset();
      n = $urandom_range(3, 20);
      a = (it == 0) ? 1020 : $urandom_range(0, 1023);
      for (int i = 0; i < int'(n); i++) begin
        while ($urandom_range(0, 3) == 0) idle(1, 2);
        r = $urandom_range(0, 15);
        if (r == 0) a = $urandom_range(0, 1023);
        if (r == 1) cyc(1'b1, 32'h0000_0400 | $urandom, $urandom, 1'b0, 1'($urandom_range(0, 1)));
        else        cyc(1'b1, a, $urandom, 1'b0, 1'($urandom_range(0, 1)));
        a = (a + 1) % 1024;
      end
      cyc(1'($urandom_range(0, 1)), a, $urandom, 1'b1, 1'($urandom_range(0, 1)));
      idle(12, 2);
      idle(8, 1);
      check_status("rnd");
    end

    @(posedge clk);
    #1;
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard drain: got %0d pending writes expected 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
